lag_correlator_accum: RTL and testbench

//  Multi-lag cross-correlator with windowed integration, dump bank and streamed readout.
//  Two sample streams pass through NUM_LAGS-deep delay lines. Each lag k accumulates
//  in1[n-k]*in2[n-(NUM_LAGS-1-k)] over a run-time window, then dumps the result.

---
 rtl/corr_pkg.sv | 38 +++
 rtl/corr_lag_cell.sv | 60 ++++++
 rtl/lag_correlator_accum.sv | 177 +++++++++++++++++
 tb/tb_lag_correlator_accum.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared definitions for the lag correlator.
//   corr_state_e : window FSM states
//   SAT_W        : working width of the saturating adder (ACC_WIDTH <= 62, DATA_WIDTH <= 31)
//   clog2        : ceil(log2(n)), minimum 1, usable in port declarations
//   sat_add      : {saturated, result} of acc + prod clamped to a w-bit signed/unsigned range
package corr_pkg;

  typedef enum logic [1:0] {IDLE, INTEGRATE, DRAIN, DUMP} corr_state_e;

  localparam int SAT_W = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // acc and prod arrive already sign/zero-extended to SAT_W bits. The sum is
  // formed one bit wider so it cannot wrap before the clamp is applied.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                             input logic [SAT_W-1:0] prod,
                                             input logic             sgn,
                                             input int               w);
    logic signed [SAT_W:0] sum, hi, lo;
    logic        [SAT_W:0] lim;
    sum = $signed({acc[SAT_W-1], acc}) + $signed({prod[SAT_W-1], prod});
    if (sgn) lim = {{SAT_W{1'b0}}, 1'b1} << (w - 1);
    else     lim = {{SAT_W{1'b0}}, 1'b1} << w;
    hi = $signed(lim - {{SAT_W{1'b0}}, 1'b1});
    if (sgn) lo = $signed(-lim);
    else     lo = '0;
    if (sum > hi)      return {1'b1, hi[SAT_W-1:0]};
    else if (sum < lo) return {1'b1, lo[SAT_W-1:0]};
    else               return {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/corr_lag_cell.sv
// One lag bin: registered product of its two taps plus a saturating accumulator.
//   clk, reset : clock, synchronous active-high reset
//   a, b       : delay-line taps for this lag
//   en         : the registered product belongs to the window, add it
//   clr        : zero the accumulator and sat flag (wins over en)
//   acc        : running sum
//   sat        : accumulator clamped at least once since the last clear
module corr_lag_cell import corr_pkg::*; #(
  parameter int DATA_WIDTH = 1,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  en,
  input  logic                  clr,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  sat
);
  localparam int   PW  = 2 * DATA_WIDTH;
  localparam logic SGN = (SIGNED != 0);

  logic [PW-1:0]    ea, eb, prod_c, prod_q;
  logic [SAT_W-1:0] ax, px;
  logic [SAT_W:0]   sum;
  logic             unused_mid;

  // Extend to PW first; the low PW bits of the product are then exact for
  // both signed and unsigned operands.
  assign ea     = {{DATA_WIDTH{SGN & a[DATA_WIDTH-1]}}, a};
  assign eb     = {{DATA_WIDTH{SGN & b[DATA_WIDTH-1]}}, b};
  assign prod_c = ea * eb;

  assign ax  = {{(SAT_W-ACC_WIDTH){SGN & acc[ACC_WIDTH-1]}}, acc};
  assign px  = {{(SAT_W-PW){SGN & prod_q[PW-1]}}, prod_q};
  assign sum = sat_add(ax, px, SGN, ACC_WIDTH);

  // Upper bits of the clamped result are pure extension of the lower ones.
  assign unused_mid = ^sum[SAT_W-1:ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc    <= '0;
      sat    <= 1'b0;
    end else begin
      prod_q <= prod_c;
      if (clr) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (en) begin
        acc <= sum[ACC_WIDTH-1:0];
        sat <= sat | sum[SAT_W];
      end
    end
  end

endmodule

// File: rtl/lag_correlator_accum.sv
// Multi-lag cross-correlator. Lag k integrates in1[n-k]*in2[n-(NUM_LAGS-1-k)]
// over a window of int_len valid samples, dumps all lags into a bank and
// streams the bank out one lag per handshake.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid, in1, in2    : sample pair strobe and data
//   start, stop           : begin integrating / close window and go idle after dump
//   int_len, continuous   : window length (0 acts as 1), re-arm after each dump
//   busy                  : window FSM not idle
//   out_valid/ready       : bank readout handshake
//   out_data, out_lag     : accumulated value and its lag index
//   out_last              : current word is the final lag
//   out_sat               : some lag clamped in the window being read out
//   overrun               : sticky, a dump found the bank still occupied
module lag_correlator_accum import corr_pkg::*; #(
  parameter int NUM_LAGS   = 16,
  parameter int DATA_WIDTH = 1,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 0,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in1,
  input  logic [DATA_WIDTH-1:0]      in2,
  input  logic                       start,
  input  logic                       stop,
  input  logic [LEN_WIDTH-1:0]       int_len,
  input  logic                       continuous,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [clog2(NUM_LAGS)-1:0] out_lag,
  output logic                       out_last,
  output logic                       out_sat,
  output logic                       overrun
);
  localparam int LAG_W  = clog2(NUM_LAGS);
  localparam int STAGES = 1;

  corr_state_e state_q, state_d;

  logic [NUM_LAGS-1:0][DATA_WIDTH-1:0] d1, d2;
  logic [NUM_LAGS-1:0][ACC_WIDTH-1:0]  acc, bank_q;
  logic [NUM_LAGS-1:0]                 sat;
  logic [STAGES:0]                     vld_pipe;
  logic                                vld_in, acc_clr;

  logic [LEN_WIDTH-1:0] cnt_q, len_q;
  logic                 cont_q, stop_q, drn_q;

  logic             vld_q, sat_q, ovr_q;
  logic [LAG_W-1:0] idx_q;
  logic             hs, last, bank_free;

  // ---------------- delay lines: shift on valid, taps read post-shift
  always_ff @(posedge clk) begin
    if (reset) begin
      d1 <= '0;
      d2 <= '0;
    end else if (in_valid) begin
      d1 <= {d1[NUM_LAGS-2:0], in1};
      d2 <= {d2[NUM_LAGS-2:0], in2};
    end
  end

  // vld_pipe[0]: taps hold a window sample; vld_pipe[1]: product register does.
  assign vld_in = in_valid && (state_q == INTEGRATE);

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], vld_in};
  end

  assign acc_clr = (state_q == IDLE) || (state_q == DUMP);

  for (genvar k = 0; k < NUM_LAGS; k++) begin : g_lag
    corr_lag_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SIGNED     (SIGNED)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .a     (d1[k]),
      .b     (d2[NUM_LAGS-1-k]),
      .en    (vld_pipe[STAGES]),
      .clr   (acc_clr),
      .acc   (acc[k]),
      .sat   (sat[k])
    );
  end

  // ---------------- window FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = INTEGRATE;
      INTEGRATE: if (stop || (in_valid && cnt_q == len_q - LEN_WIDTH'(1))) state_d = DRAIN;
      DRAIN:     if (drn_q) state_d = DUMP;
      DUMP:      state_d = (cont_q && !stop_q && !stop) ? INTEGRATE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= LEN_WIDTH'(1);
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Second DRAIN cycle is flagged so the last product has been added
      // before DUMP samples the accumulators.
      drn_q   <= (state_q == DRAIN) ? ~drn_q : 1'b0;
      if (state_q != IDLE && stop) stop_q <= 1'b1;
      if (state_q == INTEGRATE && in_valid) cnt_q <= cnt_q + LEN_WIDTH'(1);
      if (state_q == DUMP) cnt_q <= '0;
      if (state_q == IDLE && start) begin
        len_q  <= (int_len == '0) ? LEN_WIDTH'(1) : int_len;
        cont_q <= continuous;
        stop_q <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------- dump bank and readout
  assign hs        = vld_q && out_ready;
  assign last      = (idx_q == LAG_W'(NUM_LAGS - 1));
  // The bank may be refilled in the same cycle its final word leaves.
  assign bank_free = !vld_q || (hs && last);

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      sat_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (hs) begin
        if (last) begin
          vld_q <= 1'b0;
          sat_q <= 1'b0;
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + LAG_W'(1);
        end
      end
      if (state_q == DUMP) begin
        if (bank_free) begin
          bank_q <= acc;
          vld_q  <= 1'b1;
          idx_q  <= '0;
          sat_q  <= |sat;
        end else begin
          ovr_q  <= 1'b1;
        end
      end
    end
  end

  assign out_valid = vld_q;
  assign out_data  = bank_q[idx_q];
  assign out_lag   = idx_q;
  assign out_last  = last;
  assign out_sat   = sat_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_lag_correlator_accum.sv
module tb_lag_correlator_accum;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: unsigned, 1-bit samples, 32-bit accumulators
  logic        a_valid, a_in1, a_in2, a_start, a_stop, a_cont, a_ready;
  logic [23:0] a_len;
  logic        a_busy, a_ovalid, a_olast, a_osat, a_ovr;
  logic [31:0] a_odata;
  logic [1:0]  a_olag;

  lag_correlator_accum #(.NUM_LAGS(N), .DATA_WIDTH(1), .ACC_WIDTH(32), .SIGNED(0), .LEN_WIDTH(24)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in1(a_in1), .in2(a_in2),
    .start(a_start), .stop(a_stop), .int_len(a_len), .continuous(a_cont),
    .busy(a_busy), .out_valid(a_ovalid), .out_ready(a_ready), .out_data(a_odata),
    .out_lag(a_olag), .out_last(a_olast), .out_sat(a_osat), .overrun(a_ovr));

  // ---------------- instances B (unsigned 4-bit acc) and C (signed 4-bit acc), shared control
  logic        bc_valid, bc_start, bc_stop, bc_cont, bc_ready;
  logic [23:0] bc_len;
  logic        b_in1, b_in2;
  logic [1:0]  c_in1, c_in2;
  logic        b_busy, b_ovalid, b_olast, b_osat, b_ovr;
  logic        c_busy, c_ovalid, c_olast, c_osat, c_ovr;
  logic [3:0]  b_odata, c_odata;
  logic [1:0]  b_olag, c_olag;

  lag_correlator_accum #(.NUM_LAGS(N), .DATA_WIDTH(1), .ACC_WIDTH(4), .SIGNED(0), .LEN_WIDTH(24)) u_b (
    .clk(clk), .reset(reset), .in_valid(bc_valid), .in1(b_in1), .in2(b_in2),
    .start(bc_start), .stop(bc_stop), .int_len(bc_len), .continuous(bc_cont),
    .busy(b_busy), .out_valid(b_ovalid), .out_ready(bc_ready), .out_data(b_odata),
    .out_lag(b_olag), .out_last(b_olast), .out_sat(b_osat), .overrun(b_ovr));

  lag_correlator_accum #(.NUM_LAGS(N), .DATA_WIDTH(2), .ACC_WIDTH(4), .SIGNED(1), .LEN_WIDTH(24)) u_c (
    .clk(clk), .reset(reset), .in_valid(bc_valid), .in1(c_in1), .in2(c_in2),
    .start(bc_start), .stop(bc_stop), .int_len(bc_len), .continuous(bc_cont),
    .busy(c_busy), .out_valid(c_ovalid), .out_ready(bc_ready), .out_data(c_odata),
    .out_lag(c_olag), .out_last(c_olast), .out_sat(c_osat), .overrun(c_ovr));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- behavioural model of instance A
  // Windows are sets of accepted sample indices; each lag is a clamped sum of
  // products looked up in the full sample history since reset.
  localparam longint AMAX = 64'h0000_0000_FFFF_FFFF;
  int     h1[$], h2[$];
  longint m_acc[N];
  longint m_bank[$];
  bit     m_sat, m_bsat, m_ovr, m_cont, m_stp;
  int     m_ph, m_cnt, m_len;   // m_ph: 0 idle, 1 window open, 2..3 settle, 4 dump
  bit     armed = 1'b0;

  function automatic longint hist(input bit second, input int idx);
    if (idx < 0) return 0;
    return second ? longint'(h2[idx]) : longint'(h1[idx]);
  endfunction

  task automatic m_accumulate();
    int n;
    longint p;
    n = h1.size() - 1;
    for (int k = 0; k < N; k++) begin
      p = hist(1'b0, n - k) * hist(1'b1, n - (N - 1 - k));
      m_acc[k] = m_acc[k] + p;
      if (m_acc[k] > AMAX) begin m_acc[k] = AMAX; m_sat = 1'b1; end
    end
  endtask

  task automatic m_dump();
    if (m_bank.size() == 0) begin
      for (int k = 0; k < N; k++) m_bank.push_back(m_acc[k]);
      m_bsat = m_sat;
    end else begin
      m_ovr = 1'b1;
    end
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    m_sat = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      h1.delete(); h2.delete(); m_bank.delete();
      for (int k = 0; k < N; k++) m_acc[k] = 0;
      m_sat = 0; m_bsat = 0; m_ovr = 0; m_cont = 0; m_stp = 0;
      m_ph = 0; m_cnt = 0; m_len = 1;
      armed = 1'b1;
    end else if (armed) begin
      if (m_bank.size() > 0 && a_ready) begin
        void'(m_bank.pop_front());
        if (m_bank.size() == 0) m_bsat = 1'b0;
      end
      if (a_valid) begin h1.push_back(int'(a_in1)); h2.push_back(int'(a_in2)); end
      if (m_ph != 0 && a_stop) m_stp = 1'b1;
      case (m_ph)
        0: if (a_start) begin
             m_ph = 1; m_cnt = 0; m_stp = 1'b0; m_cont = a_cont;
             m_len = (a_len == 0) ? 1 : int'(a_len);
           end
        1: begin
             if (a_valid) begin m_accumulate(); m_cnt++; end
             if (m_cnt == m_len || a_stop) m_ph = 2;
           end
        2, 3: m_ph++;
        default: begin
             m_dump();
             m_cnt = 0;
             m_ph = (m_cont && !m_stp) ? 1 : 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", a_busy, longint'(m_ph != 0));
      chk("overrun", a_ovr, longint'(m_ovr));
      chk("out_valid", a_ovalid, longint'(m_bank.size() > 0));
      if (m_bank.size() > 0) begin
        chk("out_data", a_odata, m_bank[0]);
        chk("out_lag", a_olag, N - m_bank.size());
        chk("out_last", a_olast, longint'(m_bank.size() == 1));
        chk("out_sat", a_osat, longint'(m_bsat));
      end
    end
  end

  // ---------------- stimulus helpers
  longint rd_w[N];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_pulse_start(input int len, input bit cont);
    a_len = 24'(len); a_cont = cont; a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while (a_busy && c < budget) begin tick(); c++; end
    if (a_busy) timeout(name);
  endtask

  task automatic a_drain(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < N; k++) rd_w[k] = -1;
    a_ready = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (a_ovalid) begin
        rd_w[a_olag] = a_odata;
        if (a_olast) got = 1'b1;
      end
    end
    @(posedge clk); #1;
    a_ready = 1'b0;
    if (!got) timeout(name);
  endtask

  task automatic a_drain_rand(input string name);
    int c;
    c = 0;
    while (a_ovalid && c < 400) begin
      a_ready = 1'($urandom_range(0, 1));
      tick(); c++;
    end
    a_ready = 1'b0;
    if (a_ovalid) timeout(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit p1, p2, nb;
    int c;
    reset = 1'b1;
    a_valid = 0; a_in1 = 0; a_in2 = 0; a_start = 0; a_stop = 0; a_cont = 0; a_ready = 0; a_len = '0;
    bc_valid = 0; bc_start = 0; bc_stop = 0; bc_cont = 0; bc_ready = 0; bc_len = '0;
    b_in1 = 0; b_in2 = 0; c_in1 = '0; c_in2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_busy", a_busy, 0);
    chk("rst_out_valid", a_ovalid, 0);
    chk("rst_overrun", a_ovr, 0);
    chk("rst_out_data", a_odata, 0);
    chk("rst_b_out_valid", b_ovalid, 0);

    // 1: all-ones samples with delay lines pre-filled, one 8-sample window
    a_in1 = 1; a_in2 = 1; a_valid = 1;
    repeat (4) tick();
    a_pulse_start(8, 0);
    a_wait_idle("t1_idle", 40);
    a_valid = 0;
    a_drain("t1_drain");
    for (int k = 0; k < N; k++) chk("t1_word", rd_w[k], 8);

    // 2: random bits, in2 = in1 delayed by 2 valid samples, 1000-sample window
    p1 = 0; p2 = 0;
    a_valid = 0;
    a_pulse_start(1000, 0);
    c = 0;
    while (a_busy && c < 3000) begin
      a_valid = ($urandom_range(0, 9) != 0);
      nb = 1'($urandom_range(0, 1));
      a_in1 = nb; a_in2 = p2;
      if (a_valid) begin p2 = p1; p1 = nb; end
      tick(); c++;
    end
    if (a_busy) timeout("t2_window");
    a_valid = 0;
    a_drain_rand("t2_drain");

    // 5: stop after 3 of 10 samples; a second start mid-window is ignored
    a_valid = 1; a_in1 = 1; a_in2 = 1;
    repeat (4) tick();
    a_valid = 0;
    a_pulse_start(10, 0);
    a_valid = 1;
    repeat (3) tick();
    a_valid = 0;
    a_pulse_start(2, 1);
    a_stop = 1; tick(); a_stop = 0;
    a_wait_idle("t5_idle", 20);
    a_drain("t5_drain");
    for (int k = 0; k < N; k++) chk("t5_word", rd_w[k], 3);

    // 4: continuous windows with the bank never drained
    a_ready = 0;
    a_pulse_start(5, 1);
    for (int i = 0; i < 25; i++) begin
      a_valid = 1; a_in1 = 1'($urandom_range(0, 1)); a_in2 = 1'($urandom_range(0, 1));
      tick();
    end
    a_stop = 1; tick(); a_stop = 0;
    a_valid = 0;
    a_wait_idle("t4_idle", 20);
    chk("t4_overrun", a_ovr, 1);
    a_drain_rand("t4_drain");

    // 6: reset in the middle of readout, then a clean window from zeroed delay lines
    a_valid = 1; a_in1 = 1; a_in2 = 1;
    a_pulse_start(4, 0);
    a_wait_idle("t6_idle", 20);
    a_valid = 0;
    a_ready = 1;
    tick(); tick();
    chk("t6_lag_before_reset", a_olag, 2);
    a_ready = 0;
    reset = 1; tick(); reset = 0;
    chk("t6_out_valid", a_ovalid, 0);
    chk("t6_overrun", a_ovr, 0);
    chk("t6_busy", a_busy, 0);
    a_pulse_start(4, 0);
    a_valid = 1;
    a_wait_idle("t6_idle2", 20);
    a_valid = 0;
    a_drain("t6_drain");
    chk("t6_word0", rd_w[0], 1);
    chk("t6_word1", rd_w[1], 2);
    chk("t6_word2", rd_w[2], 2);
    chk("t6_word3", rd_w[3], 1);

    // 3: saturation, unsigned clamps at 15 and signed (product -1) clamps at -8
    bc_valid = 1; b_in1 = 1; b_in2 = 1; c_in1 = 2'd1; c_in2 = 2'd3;
    bc_len = 24'd40; bc_cont = 0; bc_start = 1; tick(); bc_start = 0;
    c = 0;
    while (b_busy && c < 100) begin tick(); c++; end
    if (b_busy) timeout("t3_idle");
    bc_valid = 0;
    bc_ready = 1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t3_b_valid", b_ovalid, 1);
      chk("t3_b_lag", b_olag, i);
      chk("t3_b_data", b_odata, 15);
      chk("t3_b_sat", b_osat, 1);
      chk("t3_c_data", c_odata, 8);
      chk("t3_c_sat", c_osat, 1);
    end
    @(posedge clk); #1;
    bc_ready = 0;
    chk("t3_b_empty", b_ovalid, 0);
    chk("t3_b_sat_clr", b_osat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
